// File: rtl/seqdet_pkg.sv
// Shared types for the serial 1011 detector: FSM state encoding and the target pattern.
package seqdet_pkg;
  typedef enum logic [2:0] {
    IDLE,
    S1,
    S10,
    S101,
    S1011
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end
endmodule

// File: rtl/sequence_detector.sv
// Serial detector for the pattern 1011 on the en-qualified Xin stream, with a one-cycle
// registered match pulse. Define SEQDET_COUNT_EN to build in the saturating match counter.
module sequence_detector
  import seqdet_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Xin,
  input  logic             en,
  input  logic             clr,
  output logic             Yout,
  output logic [CNT_W-1:0] count
);
  state_t state;
  state_t state_nxt;
  logic   hit;

  // The completing bit arrives while holding the longest proper prefix "101".
  assign hit = (state == S101) && (Xin == PATTERN[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      Yout  <= 1'b0;
    end else begin
      Yout <= en & hit;
      if (en) begin
        state <= state_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = Xin ? S1    : IDLE;
      S1:      state_nxt = Xin ? S1    : S10;
      S10:     state_nxt = Xin ? S101  : IDLE;
      S101:    state_nxt = Xin ? S1011 : S10;
      S1011: begin
        // Non-overlapping mode forgets the trailing "1" of the completed match.
        if (OVERLAP != 0) begin
          state_nxt = Xin ? S1 : S10;
        end else begin
          state_nxt = Xin ? S1 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEQDET_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (en & hit),
    .clr  (clr),
    .q    (count)
  );
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign count      = '0;
`endif
endmodule
